// File: rtl/sdram_arbiter_pkg.sv
// ============================================================================
// Module : sdram_arbiter_pkg
// Brief  : Host-port widths shared with sdram_controller, plus arbiter FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_arbiter_pkg;

    // Host-port widths; sdram_controller is built against the same values.
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int BSEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned k);
        return (p + k) % NUM_REQ;
    endfunction

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k)]) begin
                valid = 1'b1;
                idx   = IDX_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module : sdram_arbiter
// Brief  : Round-robin arbiter sharing one sdram_controller host port among NUM_REQ masters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*ADDR_W-1:0]  m_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  m_wdata,
    input  logic [NUM_REQ-1:0]         m_wr_en,
    input  logic [NUM_REQ*BSEL_W-1:0]  m_bytesel,
    output logic [NUM_REQ-1:0]         m_compl,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_ready,
    output logic [ADDR_W-1:0]          c_addr,
    output logic [DATA_W-1:0]          c_wdata,
    output logic                       c_wr_en,
    output logic [BSEL_W-1:0]          c_bytesel,
    input  logic [DATA_W-1:0]          c_rdata,
    input  logic                       c_compl,
    input  logic                       c_config_done,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr_en;
    logic [BSEL_W-1:0]   r_bsel;

    logic [NUM_REQ-1:0]  w_req;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_start;
    logic                w_done;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_req[gi] = |m_bytesel[gi*BSEL_W +: BSEL_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (c_config_done && w_pick_valid) begin
                    w_start      = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (c_compl) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr_en <= 1'b0;
            r_bsel  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_grant <= w_pick_idx;
                r_addr  <= m_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                r_wdata <= m_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
                r_wr_en <= m_wr_en[w_pick_idx];
                r_bsel  <= m_bytesel[int'(w_pick_idx)*BSEL_W +: BSEL_W];
            end
            // Pointer moves past the finished requester so it cannot win back-to-back.
            if (w_done) begin
                r_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
            end
        end
    end

    always_comb begin
        m_compl = '0;
        if (w_done) begin
            m_compl[r_grant] = 1'b1;
        end
    end

    assign busy      = (r_state == ST_BUSY);
    assign c_addr    = r_addr;
    assign c_wdata   = r_wdata;
    assign c_wr_en   = busy & r_wr_en;
    assign c_bytesel = busy ? r_bsel : '0;
    assign m_rdata   = c_rdata;
    assign m_ready   = c_config_done;
    assign grant_idx = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module : tb_sdram_arbiter
// Brief  : Directed self-checking bench for sdram_arbiter with a completion scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*32-1:0] m_addr;
    logic [N*16-1:0] m_wdata;
    logic [N-1:0]    m_wr_en;
    logic [N*2-1:0]  m_bytesel;
    logic [N-1:0]    m_compl;
    logic [15:0]     m_rdata;
    logic            m_ready;
    logic [31:0]     c_addr;
    logic [15:0]     c_wdata;
    logic            c_wr_en;
    logic [1:0]      c_bytesel;
    logic [15:0]     c_rdata;
    logic            c_compl;
    logic            c_config_done;
    logic            busy;
    logic [1:0]      grant_idx;

    typedef struct packed {
        logic [N-1:0] compl;
        logic [15:0]  rdata;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_wr_en       (m_wr_en),
        .m_bytesel     (m_bytesel),
        .m_compl       (m_compl),
        .m_rdata       (m_rdata),
        .m_ready       (m_ready),
        .c_addr        (c_addr),
        .c_wdata       (c_wdata),
        .c_wr_en       (c_wr_en),
        .c_bytesel     (c_bytesel),
        .c_rdata       (c_rdata),
        .c_compl       (c_compl),
        .c_config_done (c_config_done),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] d,
                           input logic w, input logic [1:0] b);
        m_addr[i*32 +: 32]  = a;
        m_wdata[i*16 +: 16] = d;
        m_wr_en[i]          = w;
        m_bytesel[i*2 +: 2] = b;
    endtask

    // Controller returns a completion; the expected requester-side pulse is queued first.
    task automatic do_compl(input int idx, input logic [15:0] rd);
        exp_t e;
        e.compl = N'(1 << idx);
        e.rdata = rd;
        sb.push_back(e);
        c_compl = 1'b1;
        c_rdata = rd;
        #1;
        e = sb.pop_front();
        chk("m_compl", m_compl, e.compl);
        chk("m_rdata", m_rdata, e.rdata);
    endtask

    initial begin
        rst = 1'b1;
        m_addr = '0; m_wdata = '0; m_wr_en = '0; m_bytesel = '0;
        c_rdata = '0; c_compl = 1'b0; c_config_done = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_m_compl", m_compl, 0);
        chk("rst_c_bytesel", c_bytesel, 0);
        chk("rst_c_wr_en", c_wr_en, 0);
        chk("rst_grant", grant_idx, 0);

        // Single read from requester 1
        set_req(1, 32'h0000_0400, 16'h0, 1'b0, 2'b11);
        tick();
        chk("rd_c_addr", c_addr, 32'h400);
        chk("rd_c_bytesel", c_bytesel, 2'b11);
        chk("rd_c_wr_en", c_wr_en, 0);
        chk("rd_grant", grant_idx, 1);
        do_compl(1, 16'hBEEF);
        tick();
        c_compl = 1'b0;
        set_req(1, 32'h0, 16'h0, 1'b0, 2'b00);
        #1;
        chk("rd_after_bytesel", c_bytesel, 0);
        chk("rd_after_busy", busy, 0);

        // Round-robin from pointer 0 with all three requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'h1000 * (i + 1), 16'h0, 1'b0, 2'b01);
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) gq.push_back(i);
        for (int s = 0; s < 2 * N; s++) begin
            int g;
            tick();
            g = gq.pop_front();
            chk("rr_busy", busy, 1);
            chk("rr_grant", grant_idx, g);
            chk("rr_c_addr", c_addr, 32'h1000 * (g + 1));
            do_compl(g, 16'(16'h100 + s));
            tick();
            c_compl = 1'b0;
            #1;
            chk("rr_compl_width", m_compl, 0);
            chk("rr_gap_bytesel", c_bytesel, 0);
        end
        m_bytesel = '0;
        tick();

        // Stability of latched fields during a write from requester 0
        set_req(0, 32'h0000_ABC0, 16'h1234, 1'b1, 2'b01);
        tick();
        chk("st_c_wr_en", c_wr_en, 1);
        set_req(0, 32'hDEAD_0000, 16'h5555, 1'b1, 2'b01);
        tick();
        chk("st_c_addr", c_addr, 32'h0000_ABC0);
        chk("st_c_wdata", c_wdata, 16'h1234);
        chk("st_c_bytesel", c_bytesel, 2'b01);
        do_compl(0, 16'h0);
        tick();
        c_compl = 1'b0;
        m_bytesel = '0;
        m_wr_en = '0;
        #1;
        chk("st_after_bytesel", c_bytesel, 0);
        chk("st_after_wr_en", c_wr_en, 0);

        // Not ready: requests held off until config done
        c_config_done = 1'b0;
        set_req(2, 32'h2222, 16'h0, 1'b0, 2'b11);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nr_busy", busy, 0);
        end
        chk("nr_m_ready", m_ready, 0);
        c_config_done = 1'b1;
        tick();
        chk("nr_busy_go", busy, 1);
        chk("nr_grant", grant_idx, 2);
        do_compl(2, 16'hCAFE);
        tick();
        c_compl = 1'b0;
        m_bytesel = '0;
        tick();

        // Stray completion while idle
        c_compl = 1'b1;
        #1;
        chk("stray_m_compl", m_compl, 0);
        tick();
        c_compl = 1'b0;
        #1;
        chk("stray_busy", busy, 0);

        // Complete requester 0 so the pointer sits at 1, then abandon requester 1 with rst
        set_req(0, 32'h10, 16'h0, 1'b0, 2'b11);
        tick();
        do_compl(0, 16'h0);
        tick();
        c_compl = 1'b0;
        m_bytesel = '0;
        set_req(1, 32'h20, 16'h7777, 1'b1, 2'b11);
        tick();
        chk("rm_busy_pre", busy, 1);
        chk("rm_wr_en_pre", c_wr_en, 1);
        rst = 1'b1;
        m_bytesel = '0;
        m_wr_en = '0;
        tick();
        rst = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_c_bytesel", c_bytesel, 0);
        chk("rm_c_wr_en", c_wr_en, 0);
        chk("rm_grant", grant_idx, 0);
        c_compl = 1'b1;
        #1;
        chk("rm_late_compl", m_compl, 0);
        tick();
        c_compl = 1'b0;
        // Pointer back at 0: requesters 0 and 2 both pending, 0 must win
        set_req(0, 32'h30, 16'h0, 1'b0, 2'b10);
        set_req(2, 32'h40, 16'h0, 1'b0, 2'b10);
        tick();
        chk("rm_ptr_grant", grant_idx, 0);
        do_compl(0, 16'h4321);
        tick();
        c_compl = 1'b0;
        m_bytesel = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
